// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit: FSM state encoding,
// default address/offset widths shared with instruction memory, and a
// sign-extension helper.
package program_counter_unit_pkg;

    localparam int unsigned DEF_ADDR_BITS   = 6;
    localparam int unsigned DEF_OFFSET_BITS = 5;

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    // Sign-extend the low 'bits' bits of value to 32 bits (1 <= bits <= 32).
    function automatic logic [31:0] sign_ext(input logic [31:0] value, input int unsigned bits);
        logic [31:0] shifted;
        shifted = value << (32 - bits);
        return 32'($signed(shifted) >>> (32 - bits));
    endfunction

endpackage

// File: rtl/program_counter_unit_if.sv
// Control/status bundle between the decode/control stage (master) and the
// program counter unit (slave). Optional call/return ports are present only
// when PC_LINK_EN is defined.
interface program_counter_unit_if
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
    parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int unsigned COUNT_BITS  = 16
);

    logic                   stall;
    logic                   branch_taken;
    logic [OFFSET_BITS-1:0] branch_offset;
    logic                   jump;
    logic [ADDR_BITS-1:0]   jump_target;
    logic                   halt_req;
    logic                   resume;
    logic [ADDR_BITS-1:0]   pc;
    logic                   pc_valid;
    logic                   halted;
    logic                   wrapped;
    logic [COUNT_BITS-1:0]  instr_count;
`ifdef PC_LINK_EN
    logic                   call;
    logic                   ret;
    logic [ADDR_BITS-1:0]   link;
`endif

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target, halt_req, resume,
`ifdef PC_LINK_EN
        output call, ret,
        input  link,
`endif
        input  pc, pc_valid, halted, wrapped, instr_count
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target, halt_req, resume,
`ifdef PC_LINK_EN
        input  call, ret,
        output link,
`endif
        output pc, pc_valid, halted, wrapped, instr_count
    );

endinterface

// File: rtl/program_counter_unit_pc_next_logic.sv
// Combinational next-PC selection for the program counter unit.
// seq_only forces a plain increment (used when resuming from HALT).
// wrap flags a sequential increment from all-ones to zero.
// Optional macro: PC_LINK_EN adds ret/call selection.
module program_counter_unit_pc_next_logic
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
    parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic [ADDR_BITS-1:0]   pc,
    input  logic                   seq_only,
    input  logic                   branch_taken,
    input  logic [OFFSET_BITS-1:0] branch_offset,
    input  logic                   jump,
    input  logic [ADDR_BITS-1:0]   jump_target,
`ifdef PC_LINK_EN
    input  logic                   call,
    input  logic                   ret,
    input  logic [ADDR_BITS-1:0]   link,
`endif
    output logic [ADDR_BITS-1:0]   pc_inc,
    output logic [ADDR_BITS-1:0]   next_pc,
    output logic                   wrap
);

    logic [ADDR_BITS-1:0] offset_addr;

    assign pc_inc      = pc + ADDR_BITS'(1);
    assign offset_addr = ADDR_BITS'(sign_ext(32'(branch_offset), OFFSET_BITS));

    // Priority mux: (ret > call >) jump > branch > increment; only increment reports wrap.
    always_comb begin
        next_pc = pc_inc;
        wrap    = 1'b0;
        if (seq_only) begin
            next_pc = pc_inc;
            wrap    = &pc;
        end
`ifdef PC_LINK_EN
        else if (ret) begin
            next_pc = link;
        end
        else if (call) begin
            next_pc = jump_target;
        end
`endif
        else if (jump) begin
            next_pc = jump_target;
        end
        else if (branch_taken) begin
            next_pc = pc_inc + offset_addr;
        end
        else begin
            next_pc = pc_inc;
            wrap    = &pc;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter unit: holds the fetch PC driving instruction memory,
// runs the BOOT/RUN/HALT control FSM and counts retired instructions.
// Optional macro: PC_LINK_EN adds call/ret ports and a link register.
module program_counter_unit
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned          ADDR_BITS    = DEF_ADDR_BITS,
    parameter int unsigned          OFFSET_BITS  = DEF_OFFSET_BITS,
    parameter logic [ADDR_BITS-1:0] RESET_VECTOR = '0,
    parameter int unsigned          COUNT_BITS   = 16
) (
    input logic                  clk,
    input logic                  rst,
    program_counter_unit_if.slave bus
);

    logic [1:0]            state;
    logic [ADDR_BITS-1:0]  pc_q;
    logic                  wrapped_q;
    logic [COUNT_BITS-1:0] count_q;
    logic [ADDR_BITS-1:0]  pc_inc;
    logic [ADDR_BITS-1:0]  next_pc;
    logic                  wrap;
    logic                  run_go;
    logic                  advance;

    // Instruction at pc retires whenever RUN is not stalled (halt_req included).
    assign run_go  = (state == RUN) && !bus.stall;
    // pc loads next_pc on an unstalled non-halting RUN cycle, or on resume from HALT.
    assign advance = (run_go && !bus.halt_req) || ((state == HALT) && bus.resume);

`ifdef PC_LINK_EN
    logic [ADDR_BITS-1:0] link_q;
`endif

    program_counter_unit_pc_next_logic #(
        .ADDR_BITS   (ADDR_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_pc_next_logic (
        .pc            (pc_q),
        .seq_only      (state != RUN),
        .branch_taken  (bus.branch_taken),
        .branch_offset (bus.branch_offset),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
`ifdef PC_LINK_EN
        .call          (bus.call),
        .ret           (bus.ret),
        .link          (link_q),
`endif
        .pc_inc        (pc_inc),
        .next_pc       (next_pc),
        .wrap          (wrap)
    );

    // PC, FSM state, wrap pulse and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc_q      <= RESET_VECTOR;
            wrapped_q <= 1'b0;
            count_q   <= '0;
        end else begin
            wrapped_q <= advance && wrap;
            if (advance) begin
                pc_q <= next_pc;
            end
            if (run_go) begin
                count_q <= count_q + COUNT_BITS'(1);
            end
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (run_go && bus.halt_req) state <= HALT;
                HALT:    if (bus.resume) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

`ifdef PC_LINK_EN
    // Link register captures the return address on a taken call.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_q <= '0;
        end else if (advance && (state == RUN) && !bus.ret && bus.call) begin
            link_q <= pc_inc;
        end
    end

    assign bus.link = link_q;
`endif

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = (state == RUN);
    assign bus.halted      = (state == HALT);
    assign bus.wrapped     = wrapped_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: the driver applies one directed
// vector per cycle and queues the hand-computed outputs expected after the
// next rising edge; the monitor pops and compares after each edge.
module tb_program_counter_unit;

    logic clk;
    logic rst;

    typedef struct {
        int          step;
        logic [5:0]  pc;
        logic        valid;
        logic        halted;
        logic        wrapped;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    program_counter_unit_if #(.ADDR_BITS(6), .OFFSET_BITS(5), .COUNT_BITS(16)) bus ();

    program_counter_unit #(
        .ADDR_BITS    (6),
        .OFFSET_BITS  (5),
        .RESET_VECTOR (6'd0),
        .COUNT_BITS   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: actual %0d required %0d", name, step, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",          e.step, 32'(bus.pc),          32'(e.pc));
                check("pc_valid",    e.step, 32'(bus.pc_valid),    32'(e.valid));
                check("halted",      e.step, 32'(bus.halted),      32'(e.halted));
                check("wrapped",     e.step, 32'(bus.wrapped),     32'(e.wrapped));
                check("instr_count", e.step, 32'(bus.instr_count), 32'(e.count));
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic st, input logic br, input logic [4:0] off,
                       input logic jp, input logic [5:0] tg, input logic hr, input logic rs,
                       input logic [5:0] epc, input logic ev, input logic eh, input logic ew,
                       input logic [15:0] ec);
        exp_t e;
        rst               = r;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump          = jp;
        bus.jump_target   = tg;
        bus.halt_req      = hr;
        bus.resume        = rs;
        step_no++;
        e.step    = step_no;
        e.pc      = epc;
        e.valid   = ev;
        e.halted  = eh;
        e.wrapped = ew;
        e.count   = ec;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.halt_req      = 1'b0;
        bus.resume        = 1'b0;
`ifdef PC_LINK_EN
        bus.call          = 1'b0;
        bus.ret           = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;

        //  r  st br off       jp tg  hr rs   pc  v  h  w  cnt
        cyc(1, 0, 0, 5'd0,     0, 0,  0, 0,   0,  0, 0, 0, 0);   // reset -> BOOT
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   0,  1, 0, 0, 0);   // BOOT -> RUN
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   1,  1, 0, 0, 1);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   2,  1, 0, 0, 2);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   3,  1, 0, 0, 3);
        cyc(0, 0, 0, 5'd0,     1, 10, 0, 0,   10, 1, 0, 0, 4);
        cyc(0, 0, 1, 5'b11101, 0, 0,  0, 0,   8,  1, 0, 0, 5);   // 10+1-3
        cyc(0, 0, 0, 5'd0,     1, 2,  0, 0,   2,  1, 0, 0, 6);
        cyc(0, 0, 1, 5'b11011, 0, 0,  0, 0,   62, 1, 0, 0, 7);   // 2+1-5 wraps silently
        cyc(0, 0, 0, 5'd0,     1, 20, 0, 0,   20, 1, 0, 0, 8);
        cyc(0, 0, 1, 5'd4,     1, 40, 0, 0,   40, 1, 0, 0, 9);   // jump beats branch
        cyc(0, 0, 0, 5'd0,     1, 63, 0, 0,   63, 1, 0, 0, 10);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   0,  1, 0, 1, 11);  // sequential wrap
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   1,  1, 0, 0, 12);  // pulse ends
        cyc(0, 0, 0, 5'd0,     1, 7,  0, 0,   7,  1, 0, 0, 13);
        cyc(0, 1, 0, 5'd0,     1, 33, 0, 0,   7,  1, 0, 0, 13);  // stall holds
        cyc(0, 1, 0, 5'd0,     1, 33, 0, 0,   7,  1, 0, 0, 13);
        cyc(0, 1, 0, 5'd0,     1, 33, 0, 0,   7,  1, 0, 0, 13);
        cyc(0, 0, 0, 5'd0,     1, 33, 0, 0,   33, 1, 0, 0, 14);  // jump after stall
        cyc(0, 0, 0, 5'd0,     1, 63, 0, 0,   63, 1, 0, 0, 15);
        cyc(0, 1, 0, 5'd0,     0, 0,  0, 0,   63, 1, 0, 0, 15);  // stall at 63: no wrap
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   0,  1, 0, 1, 16);
        cyc(0, 0, 0, 5'd0,     1, 12, 0, 0,   12, 1, 0, 0, 17);
        cyc(0, 0, 0, 5'd0,     1, 50, 1, 0,   12, 0, 1, 0, 18);  // halt beats jump
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   12, 0, 1, 0, 18);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   12, 0, 1, 0, 18);
        cyc(0, 1, 1, 5'd3,     1, 50, 0, 0,   12, 0, 1, 0, 18);  // ignored in HALT
        cyc(0, 0, 1, 5'd3,     0, 0,  0, 0,   12, 0, 1, 0, 18);
        cyc(0, 0, 0, 5'd0,     1, 50, 1, 0,   12, 0, 1, 0, 18);
        cyc(0, 0, 0, 5'd0,     0, 0,  1, 1,   13, 1, 0, 0, 18);  // resume beats halt_req
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   14, 1, 0, 0, 19);
        cyc(0, 0, 0, 5'd0,     1, 63, 0, 0,   63, 1, 0, 0, 20);
        cyc(0, 0, 0, 5'd0,     0, 0,  1, 0,   63, 0, 1, 0, 21);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 1,   0,  1, 0, 1, 21);  // resume wraps
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   1,  1, 0, 0, 22);
        cyc(0, 0, 0, 5'd0,     1, 30, 0, 0,   30, 1, 0, 0, 23);
        cyc(0, 0, 0, 5'd0,     0, 0,  1, 0,   30, 0, 1, 0, 24);
        cyc(1, 0, 0, 5'd0,     0, 0,  0, 0,   0,  0, 0, 0, 0);   // reset from HALT
        cyc(0, 0, 0, 5'd0,     1, 9,  0, 0,   0,  1, 0, 0, 0);   // BOOT ignores jump
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   1,  1, 0, 0, 1);
        cyc(0, 0, 0, 5'd0,     1, 5,  0, 0,   5,  1, 0, 0, 2);
        cyc(1, 1, 0, 5'd0,     1, 9,  1, 0,   0,  0, 0, 0, 0);   // reset beats stall
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   0,  1, 0, 0, 0);
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   1,  1, 0, 0, 1);
        cyc(0, 0, 0, 5'd0,     1, 60, 0, 0,   60, 1, 0, 0, 2);
        cyc(0, 0, 1, 5'd5,     0, 0,  0, 0,   2,  1, 0, 0, 3);   // 60+1+5 wraps silently
        cyc(0, 0, 0, 5'd0,     0, 0,  0, 0,   3,  1, 0, 0, 4);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Fetch-address generator sitting directly upstream of the instruction memory. It holds the program counter and drives it as the instruction-memory address. Each cycle it advances the PC by increment, relative branch or absolute jump, under control of the downstream decode/control stage. It also provides stall, halt/resume and a retired-instruction counter.

Parameters:
ADDR_BITS, 6, PC / instruction-memory address width (64 words)
OFFSET_BITS, 5, width of signed two's-complement branch offset
RESET_VECTOR, 0, PC value loaded on reset
COUNT_BITS, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC and state this cycle
branch_taken  input  1  PC <= PC + 1 + sign_ext(branch_offset)
branch_offset  input  OFFSET_BITS  signed relative offset
jump  input  1  PC <= jump_target
jump_target  input  ADDR_BITS  absolute target
halt_req  input  1  enter HALT after the current instruction
resume  input  1  leave HALT; continue at PC+1
pc  output  ADDR_BITS  current PC, wired to instruction-memory address
pc_valid  output  1  pc addresses an instruction to execute this cycle
halted  output  1  unit is in HALT
wrapped  output  1  one-cycle pulse when sequential increment wraps max→0
instr_count  output  COUNT_BITS  instructions retired since reset

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: pc=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0, wrapped=0, instr_count=0. rst has priority over every other input in any state, including mid-HALT or during stall.
- BOOT: lasts exactly one cycle with pc_valid=0 (memory read settles) and then goes to RUN. Inputs are ignored in BOOT.
- RUN: pc_valid=1. The instruction at pc retires at the clock edge unless stall=1.
- RUN update priority, highest first: stall, halt_req, jump, branch_taken, increment.
  - stall=1: pc, state and instr_count all hold. wrapped=0.
  - halt_req=1: instruction retires (instr_count+1). pc holds. Next state is HALT.
  - jump=1: pc <= jump_target. Overrides branch_taken if both are asserted.
  - branch_taken=1: pc <= pc + 1 + sign_ext(offset), computed modulo 2^ADDR_BITS. Wrap in either direction is legal and silent (wrapped=0).
  - otherwise: pc <= pc + 1. If pc was all-ones, the result is 0 and wrapped pulses for exactly one cycle.
- HALT: pc_valid=0, halted=1, pc and instr_count hold. stall, jump and branch are ignored.
  - resume=1: pc <= pc + 1 and state goes to RUN (halted=0 next cycle). wrapped applies as for a normal increment.
  - halt_req together with resume in HALT: resume wins.
- instr_count increments once per retired instruction and wraps silently at 2^COUNT_BITS.
- Latency: every pc change is visible on the cycle after the controlling input. pc is a registered output with no combinational input→pc path.

Optional Feature:
PC_LINK_EN
- With it: adds ports call (input 1), ret (input 1) and link (output ADDR_BITS, reset 0).
  - call behaves as jump to jump_target and also sets link <= pc + 1.
  - ret sets pc <= link.
  - Priority: halt_req > ret > call > jump > branch > increment.
- Without it: the ports and link register are absent and behaviour is exactly as above.

Decomposition:
- Shared package: state encoding localparams (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the default ADDR_BITS/OFFSET_BITS constants shared with instruction memory, and a sign-extension function.
- One natural sub-module: pc_next_logic, the combinational next-PC mux/adder producing next_pc and the wrap flag. Top level holds registers, FSM and counter.

Test Plan:
- Reset then 4 idle cycles → cycle 1 pc=0, pc_valid=0. Then pc=0,1,2,3 with pc_valid=1 and instr_count 0,1,2,3.
- pc=10, branch_taken, offset=-3 (5'b11101) → pc=8 next cycle. At pc=2, offset=-5 → pc=62 (wrap), wrapped=0.
- pc=20, jump=1 with jump_target=40 and branch_taken=1 with offset=+4 → pc=40. At pc=63 with no control input → pc=0, wrapped=1 for one cycle.
- pc=7, stall=1 for 3 cycles with jump asserted → pc stays 7, instr_count unchanged. After stall drops, jump applies.
- pc=12, halt_req → halted=1, pc=12, pc_valid=0, count+1. 5 idle cycles → no change. resume → pc=13, RUN.
- Assert rst while in HALT with pc=30 → next cycle pc=0, BOOT, halted=0, instr_count=0.
